// File: rtl/div_unit.sv
// rtl/div_unit.sv - iterative radix-2 RV32M divide/remainder unit
//
// Purpose: executes DIV, DIVU, REM and REMU with a restoring shift/subtract
// loop (one quotient bit per cycle), one operation in flight at a time.
// The result is held in div_pkt until the consumer acknowledges it.
//
// Ports:
//   clk        clock
//   rst        synchronous active-high reset
//   ex_pkt     issued instruction (i_valid, i_funct3, rs1_data, rs2_data used)
//   div_ready  unit can accept ex_pkt this cycle
//   div_pkt    completed instruction, rd_data filled, i_valid marks result
//   div_ack    consumer has taken div_pkt this cycle
//   flush      (DIV_FLUSH_EN only) discard the in-flight operation
//
// Optional feature macro: DIV_FLUSH_EN adds the flush input.

package div_unit_pkg;
  typedef struct packed {
    logic        i_valid;
    logic [2:0]  i_funct3;
    logic [31:0] pc;
    logic [4:0]  rd_addr;
    logic [5:0]  rob_tag;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [31:0] rd_data;
  } instr_pkt;
endpackage

module div_unit
  import div_unit_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     rst,
  input  instr_pkt ex_pkt,
  output logic     div_ready,
  output instr_pkt div_pkt,
  input  logic     div_ack
`ifdef DIV_FLUSH_EN
  ,
  input  logic     flush
`endif
);

  localparam int CW = $clog2(XLEN);

  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

  state_t            state, state_nxt;
  logic [CW-1:0]     cnt;
  instr_pkt          pkt_q;
  logic [XLEN-1:0]   n_q;     // dividend shifting out, quotient bits shifting in
  logic [XLEN-1:0]   d_q;     // divisor magnitude
  logic [XLEN-1:0]   r_q;     // partial remainder (always < divisor, so fits XLEN)
  logic [XLEN-1:0]   res_q;
  logic              neg_q, neg_r;
  logic              flush_i;

`ifdef DIV_FLUSH_EN
  assign flush_i = flush;
`else
  assign flush_i = 1'b0;
`endif

  assign div_ready = (state == IDLE) && !flush_i;

  logic accept;
  assign accept = ex_pkt.i_valid && div_ready;

  // Operand decode at accept. funct3[0] = 0 selects signed, funct3[1] = 1 selects remainder.
  logic            is_signed, a_neg, b_neg, div_zero, ovf, special;
  logic [XLEN-1:0] a, b, a_mag, b_mag, special_res;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  always_comb begin
    is_signed   = ~ex_pkt.i_funct3[0];
    a           = ex_pkt.rs1_data;
    b           = ex_pkt.rs2_data;
    a_neg       = is_signed & a[XLEN-1];
    b_neg       = is_signed & b[XLEN-1];
    a_mag       = a_neg ? (~a + 1'b1) : a;
    b_mag       = b_neg ? (~b + 1'b1) : b;
    div_zero    = (b == '0);
    ovf         = is_signed && (a == MIN_NEG) && (b == '1);
    special     = div_zero || ovf;
    special_res = '0;
    if (div_zero)
      special_res = ex_pkt.i_funct3[1] ? a : '1;
    else if (ovf)
      special_res = ex_pkt.i_funct3[1] ? '0 : MIN_NEG;
  end

  // One restoring step: shift the next dividend bit into the remainder and
  // subtract the divisor when it fits.
  logic [XLEN:0]   r_shift, r_sub;
  logic            q_bit;
  logic [XLEN-1:0] quo_fix, rem_fix;

  always_comb begin
    r_shift = {r_q, n_q[XLEN-1]};
    r_sub   = r_shift - {1'b0, d_q};
    q_bit   = (r_shift >= {1'b0, d_q});
    quo_fix = neg_q ? (~n_q + 1'b1) : n_q;
    rem_fix = neg_r ? (~r_q + 1'b1) : r_q;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = special ? DONE : CALC;
      CALC: if (cnt == '0) state_nxt = FIX;
      FIX:  state_nxt = DONE;
      DONE: if (div_ack) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (flush_i)
      state_nxt = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (accept) begin
      pkt_q <= ex_pkt;
      n_q   <= a_mag;
      d_q   <= b_mag;
      r_q   <= '0;
      neg_q <= a_neg ^ b_neg;
      neg_r <= a_neg;
      cnt   <= CW'(XLEN - 1);
      if (special)
        res_q <= special_res;
    end else if (state == CALC) begin
      n_q <= {n_q[XLEN-2:0], q_bit};
      r_q <= q_bit ? r_sub[XLEN-1:0] : r_shift[XLEN-1:0];
      cnt <= cnt - 1'b1;
    end else if (state == FIX) begin
      res_q <= pkt_q.i_funct3[1] ? rem_fix : quo_fix;
    end
  end

  always_comb begin
    div_pkt         = pkt_q;
    div_pkt.i_valid = (state == DONE);
    div_pkt.rd_data = res_q;
  end

endmodule

// File: tb/tb_div_unit.sv
// tb/tb_div_unit.sv - scoreboard testbench for div_unit
module tb_div_unit;
  import div_unit_pkg::*;

  logic     clk = 1'b0;
  logic     rst;
  instr_pkt ex_pkt;
  logic     div_ready;
  instr_pkt div_pkt;
  logic     div_ack;
`ifdef DIV_FLUSH_EN
  logic     flush = 1'b0;
`endif

  div_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .ex_pkt    (ex_pkt),
    .div_ready (div_ready),
    .div_pkt   (div_pkt),
    .div_ack   (div_ack)
`ifdef DIV_FLUSH_EN
    ,
    .flush     (flush)
`endif
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [31:0] rd;
    bit          chk_data;
    int          t;
    int          lat;
    logic [2:0]  f3;
    logic [31:0] pc;
    logic [4:0]  rd_addr;
    logic [5:0]  tag;
    logic [31:0] a;
    logic [31:0] b;
  } exp_t;

  exp_t sb[$];

  // Reference: plain language-level signed/unsigned division with the RISC-V
  // rules for divide-by-zero and signed overflow.
  function automatic void model(input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] b, output logic [31:0] rd,
                                output int lat);
    logic [31:0] q, r;
    bit sgn;
    int sa, sb_i;
    sgn  = (f3 == 3'b100) || (f3 == 3'b110);
    sa   = $signed(a);
    sb_i = $signed(b);
    if (b == 32'd0) begin
      q = 32'hFFFF_FFFF; r = a; lat = 1;
    end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = 32'h8000_0000; r = 32'd0; lat = 1;
    end else if (sgn) begin
      q = sa / sb_i; r = sa % sb_i; lat = 34;
    end else begin
      q = a / b; r = a % b; lat = 34;
    end
    rd = (f3 == 3'b110 || f3 == 3'b111) ? r : q;
  endfunction

  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input bit push, output int t);
    int n;
    exp_t e;
    instr_pkt p;
    logic [31:0] rd;
    int lat;
    n = 0;
    while (!div_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (div_ready !== 1'b1) begin
      errors++;
      $display("FAIL issue_ready: div_ready=%b required 1", div_ready);
    end
    p          = '0;
    p.i_valid  = 1'b1;
    p.i_funct3 = f3;
    p.pc       = $urandom;
    p.rd_addr  = 5'($urandom_range(0, 31));
    p.rob_tag  = 6'($urandom_range(0, 63));
    p.rs1_data = a;
    p.rs2_data = b;
    p.rd_data  = $urandom;
    ex_pkt     = p;
    t          = cyc;
    if (push) begin
      model(f3, a, b, rd, lat);
      e.rd       = rd;
      e.chk_data = f3[2];
      e.t        = t;
      e.lat      = (f3[2]) ? lat : 34;
      e.f3       = f3;
      e.pc       = p.pc;
      e.rd_addr  = p.rd_addr;
      e.tag      = p.rob_tag;
      e.a        = a;
      e.b        = b;
      sb.push_back(e);
    end
    @(negedge clk);
    ex_pkt.i_valid = 1'b0;
  endtask

  task automatic wait_done(input int hold);
    int n;
    instr_pkt snap;
    n = 0;
    while (!div_pkt.i_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (div_pkt.i_valid !== 1'b1) begin
      errors++;
      $display("FAIL done_timeout: i_valid=%b required 1", div_pkt.i_valid);
    end
    snap = div_pkt;
    for (int i = 0; i < hold; i++) begin
      if (i == 0) begin
        // an issue attempt while busy must be ignored
        ex_pkt          = '0;
        ex_pkt.i_valid  = 1'b1;
        ex_pkt.i_funct3 = 3'b101;
        ex_pkt.rs1_data = 32'd77;
        ex_pkt.rs2_data = 32'd7;
      end
      @(negedge clk);
      checks++;
      if (div_pkt !== snap || div_ready !== 1'b0) begin
        errors++;
        $display("FAIL stall_hold: rd_data=%h valid=%b ready=%b required rd_data=%h valid=1 ready=0",
                 div_pkt.rd_data, div_pkt.i_valid, div_ready, snap.rd_data);
      end
    end
    ex_pkt.i_valid = 1'b0;
    div_ack = 1'b1;
    @(negedge clk);
    div_ack = 1'b0;
    checks++;
    if (div_pkt.i_valid !== 1'b0 || div_ready !== 1'b1) begin
      errors++;
      $display("FAIL after_ack: valid=%b ready=%b required valid=0 ready=1",
               div_pkt.i_valid, div_ready);
    end
  endtask

  task automatic do_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                       input int hold);
    int t;
    issue(f3, a, b, 1'b1, t);
    wait_done(hold);
  endtask

  // Monitor: compares each newly presented result against the scoreboard.
  initial begin : monitor
    bit   prev_v;
    exp_t e;
    prev_v = 1'b0;
    forever begin
      @(negedge clk);
      if (div_pkt.i_valid === 1'b1 && !prev_v) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_result: rd_data=%h with no pending operation", div_pkt.rd_data);
        end else begin
          e = sb.pop_front();
          if (e.chk_data && div_pkt.rd_data !== e.rd) begin
            errors++;
            $display("FAIL rd_data f3=%b a=%h b=%h: got %h required %h",
                     e.f3, e.a, e.b, div_pkt.rd_data, e.rd);
          end
          checks++;
          if (cyc != e.t + e.lat) begin
            errors++;
            $display("FAIL latency f3=%b a=%h b=%h: got %0d required %0d",
                     e.f3, e.a, e.b, cyc - e.t, e.lat);
          end
          checks++;
          if (div_pkt.pc !== e.pc || div_pkt.rd_addr !== e.rd_addr || div_pkt.rob_tag !== e.tag ||
              div_pkt.i_funct3 !== e.f3 || div_pkt.rs1_data !== e.a || div_pkt.rs2_data !== e.b) begin
            errors++;
            $display("FAIL pkt_fields: pc=%h rd=%0d tag=%0d got, required pc=%h rd=%0d tag=%0d",
                     div_pkt.pc, div_pkt.rd_addr, div_pkt.rob_tag, e.pc, e.rd_addr, e.tag);
          end
        end
      end
      prev_v = (div_pkt.i_valid === 1'b1);
    end
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stim
    int t;
    logic [2:0]  f3;
    logic [31:0] a, b;
    rst     = 1'b1;
    div_ack = 1'b0;
    ex_pkt  = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (div_pkt.i_valid !== 1'b0 || div_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: valid=%b ready=%b required valid=0 ready=1",
               div_pkt.i_valid, div_ready);
    end
    rst = 1'b0;
    @(negedge clk);

    // directed cases
    do_op(3'b100, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(3'b110, 32'hFFFF_FFF9, 32'd2, 0);
    do_op(3'b100, 32'd100, 32'hFFFF_FFF9, 0);
    do_op(3'b101, 32'hFFFF_FFFF, 32'h10, 0);
    do_op(3'b111, 32'hFFFF_FFFF, 32'h10, 0);
    do_op(3'b100, 32'd5, 32'd0, 0);
    do_op(3'b111, 32'h8000_0000, 32'd0, 0);
    do_op(3'b110, 32'hFFFF_FFF9, 32'd0, 0);
    do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    do_op(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    // backpressure then back-to-back issue
    do_op(3'b101, 32'd1000, 32'd7, 10);
    do_op(3'b100, 32'hFFFF_FF00, 32'd3, 0);
    do_op(3'b101, 32'd5, 32'd0, 10);
    do_op(3'b100, 32'd6, 32'd0, 0);
    // illegal funct3: only handshake/latency/fields are checked
    do_op(3'b011, 32'd50, 32'd5, 0);

    // reset mid-calculation
    issue(3'b100, 32'd12345, 32'd17, 1'b0, t);
    while (cyc < t + 10) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (div_pkt.i_valid !== 1'b0 || div_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_abort: valid=%b ready=%b required valid=0 ready=1",
               div_pkt.i_valid, div_ready);
    end
    do_op(3'b101, 32'd9, 32'd3, 0);

`ifdef DIV_FLUSH_EN
    issue(3'b100, 32'd12345, 32'd17, 1'b0, t);
    while (cyc < t + 10) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    checks++;
    if (div_pkt.i_valid !== 1'b0 || div_ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_abort: valid=%b ready=%b required valid=0 ready=1",
               div_pkt.i_valid, div_ready);
    end
    do_op(3'b101, 32'd9, 32'd3, 0);
`endif

    // randomized operations
    for (int i = 0; i < 40; i++) begin
      f3 = 3'b100 | 3'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: a = $urandom;
        1: a = 32'($urandom_range(0, 100));
        2: a = 32'h8000_0000;
        default: a = -32'($urandom_range(1, 1000));
      endcase
      case ($urandom_range(0, 5))
        0: b = 32'd0;
        1: b = 32'hFFFF_FFFF;
        2: b = 32'($urandom_range(1, 20));
        3: b = -32'($urandom_range(1, 20));
        default: b = $urandom;
      endcase
      do_op(f3, a, b, $urandom_range(0, 3));
    end

    repeat (5) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d pending required 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
